// File: rtl/pwm_duty_sequencer.sv
// ============================================================================
// Module   : pwm_duty_sequencer
// Brief    : Ramps a PWM duty toward a requested target on period boundaries,
//            with immediate cut-off on fault or disable.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_duty_sequencer #(
    parameter int DATA_WIDTH   = 10,
    parameter int RAMP_STEP    = 8,
    parameter int STEP_PERIODS = 4
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  enable,
    input  logic                  fault_in,
    input  logic                  fault_clr,
    input  logic                  req_valid,
    input  logic [DATA_WIDTH-1:0] req_duty,
    output logic                  req_ready,
    output logic [DATA_WIDTH-1:0] treshold,
    output logic                  drive_en,
    output logic [DATA_WIDTH-1:0] cur_duty,
    output logic                  busy,
    output logic                  fault_active
);

    localparam int                  c_pdiv_w    = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam logic [DATA_WIDTH-1:0] c_ones    = {DATA_WIDTH{1'b1}};
    localparam logic [DATA_WIDTH-1:0] c_zero    = '0;
    localparam logic [DATA_WIDTH-1:0] c_one     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH:0]   c_step    = (DATA_WIDTH+1)'(RAMP_STEP);
    localparam logic [c_pdiv_w-1:0]   c_pdiv_last = c_pdiv_w'(STEP_PERIODS - 1);
    localparam logic [c_pdiv_w-1:0]   c_pdiv_one  = {{(c_pdiv_w-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_pcnt;
    logic [c_pdiv_w-1:0]   r_pdiv, w_pdiv_nxt;
    logic [DATA_WIDTH-1:0] r_cur, w_cur_nxt;
    logic [DATA_WIDTH-1:0] r_target, w_target_nxt;
    logic [DATA_WIDTH-1:0] r_tresh, w_tresh_nxt;
    logic                  r_drive, w_drive_nxt;

    logic                  w_period_end;
    logic                  w_accept;
    logic [DATA_WIDTH:0]   w_tgt_ext, w_cur_ext, w_dist, w_mag, w_stepped;
    logic                  w_up;
    logic [DATA_WIDTH-1:0] w_cur_step;
    logic [DATA_WIDTH-1:0] w_step_tresh;

    assign w_period_end = (r_pcnt == c_ones);
    assign req_ready    = rstN & (r_state != ST_FAULT) & ~fault_in;
    assign w_accept     = req_valid & req_ready;

    // Step toward target one bit wider than the duty so neither direction can wrap.
    assign w_tgt_ext    = {1'b0, r_target};
    assign w_cur_ext    = {1'b0, r_cur};
    assign w_up         = (w_tgt_ext >= w_cur_ext);
    assign w_dist       = w_up ? (w_tgt_ext - w_cur_ext) : (w_cur_ext - w_tgt_ext);
    assign w_mag        = (w_dist > c_step) ? c_step : w_dist;
    assign w_stepped    = w_up ? (w_cur_ext + w_mag) : (w_cur_ext - w_mag);
    assign w_cur_step   = w_stepped[DATA_WIDTH-1:0];

    // Comparator fires when pcnt >= treshold, so -duty yields exactly duty high counts.
    assign w_step_tresh = (w_cur_step == c_zero) ? c_ones : (~w_cur_step + c_one);

    always_comb begin
        w_state_nxt  = r_state;
        w_pdiv_nxt   = r_pdiv;
        w_cur_nxt    = r_cur;
        w_target_nxt = r_target;
        w_tresh_nxt  = r_tresh;
        w_drive_nxt  = r_drive;

        if (fault_in) begin
            w_state_nxt  = ST_FAULT;
            w_pdiv_nxt   = '0;
            w_cur_nxt    = c_zero;
            w_target_nxt = c_zero;
            w_tresh_nxt  = c_ones;
            w_drive_nxt  = 1'b0;
        end else if (r_state == ST_FAULT) begin
            if (fault_clr) begin
                w_state_nxt = ST_IDLE;
            end
        end else if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_pdiv_nxt  = '0;
            w_cur_nxt   = c_zero;
            w_tresh_nxt = c_ones;
            w_drive_nxt = 1'b0;
            if (w_accept) begin
                w_target_nxt = req_duty;
            end
        end else begin
            if (w_accept) begin
                w_target_nxt = req_duty;
            end
            case (r_state)
                ST_IDLE: begin
                    if (r_target != c_zero) begin
                        w_state_nxt = ST_RAMP;
                        w_pdiv_nxt  = '0;
                    end
                end
                ST_HOLD: begin
                    if (r_target != r_cur) begin
                        w_state_nxt = ST_RAMP;
                        w_pdiv_nxt  = '0;
                    end
                end
                ST_RAMP: begin
                    if (w_period_end) begin
                        if (r_pdiv == c_pdiv_last) begin
                            w_pdiv_nxt  = '0;
                            w_cur_nxt   = w_cur_step;
                            w_tresh_nxt = w_step_tresh;
                            w_drive_nxt = (w_cur_step != c_zero);
                            if (w_cur_step == r_target) begin
                                w_state_nxt = (r_target == c_zero) ? ST_IDLE : ST_HOLD;
                            end
                        end else begin
                            w_pdiv_nxt = r_pdiv + c_pdiv_one;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            r_state  <= ST_IDLE;
            r_pcnt   <= c_zero;
            r_pdiv   <= '0;
            r_cur    <= c_zero;
            r_target <= c_zero;
            r_tresh  <= c_ones;
            r_drive  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pcnt   <= r_pcnt + c_one;
            r_pdiv   <= w_pdiv_nxt;
            r_cur    <= w_cur_nxt;
            r_target <= w_target_nxt;
            r_tresh  <= w_tresh_nxt;
            r_drive  <= w_drive_nxt;
        end
    end

    assign treshold     = r_tresh;
    assign drive_en     = r_drive;
    assign cur_duty     = r_cur;
    assign busy         = (r_state == ST_RAMP);
    assign fault_active = (r_state == ST_FAULT);

endmodule

`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
// ============================================================================
// Module   : tb_pwm_duty_sequencer
// Brief    : Directed self-checking bench for pwm_duty_sequencer (small and wide builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pwm_duty_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small build: 4-bit counter, step 3, every 2 periods
    logic       s_rstN, s_en, s_fin, s_fclr, s_rv;
    logic [3:0] s_rd;
    logic       s_rr, s_de, s_busy, s_fa;
    logic [3:0] s_tr, s_cd;

    // Wide build: 10-bit counter, single full-range step per period
    logic       b_rstN, b_en, b_fin, b_fclr, b_rv;
    logic [9:0] b_rd;
    logic       b_rr, b_de, b_busy, b_fa;
    logic [9:0] b_tr, b_cd;

    pwm_duty_sequencer #(.DATA_WIDTH(4), .RAMP_STEP(3), .STEP_PERIODS(2)) u_small (
        .clk(clk), .rstN(s_rstN), .enable(s_en), .fault_in(s_fin), .fault_clr(s_fclr),
        .req_valid(s_rv), .req_duty(s_rd), .req_ready(s_rr), .treshold(s_tr),
        .drive_en(s_de), .cur_duty(s_cd), .busy(s_busy), .fault_active(s_fa)
    );

    pwm_duty_sequencer #(.DATA_WIDTH(10), .RAMP_STEP(1023), .STEP_PERIODS(1)) u_big (
        .clk(clk), .rstN(b_rstN), .enable(b_en), .fault_in(b_fin), .fault_clr(b_fclr),
        .req_valid(b_rv), .req_duty(b_rd), .req_ready(b_rr), .treshold(b_tr),
        .drive_en(b_de), .cur_duty(b_cd), .busy(b_busy), .fault_active(b_fa)
    );

    // Reference PWM counters, reset and clocked like the real PWM block
    logic [3:0] m_s;
    logic [9:0] m_b;
    always @(posedge clk) begin
        if (!s_rstN) m_s <= 4'd0; else m_s <= m_s + 4'd1;
        if (!b_rstN) m_b <= 10'd0; else m_b <= m_b + 10'd1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_pcnt(input bit big, input int val, input string tag);
        int c;
        logic [9:0] m;
        c = 0;
        do begin
            tick();
            c++;
            m = big ? m_b : {6'd0, m_s};
        end while ((int'(m) != val) && (c < 2000));
        check(tag, 32'(m), 32'(val));
    endtask

    task automatic wait_wrap(input bit big, input int n);
        for (int k = 0; k < n; k++) wait_pcnt(big, 0, "wrap_reached");
    endtask

    int hi_cnt;

    initial begin
        s_rstN = 1'b0; s_en = 1'b0; s_fin = 1'b0; s_fclr = 1'b0; s_rv = 1'b0; s_rd = 4'd0;
        b_rstN = 1'b0; b_en = 1'b0; b_fin = 1'b0; b_fclr = 1'b0; b_rv = 1'b0; b_rd = 10'd0;

        // 1. reset and idle
        tick(3);
        check("rst_tresh", s_tr, 15);
        check("rst_drive", s_de, 0);
        check("rst_cur", s_cd, 0);
        check("rst_busy", s_busy, 0);
        check("rst_fault", s_fa, 0);
        check("rst_ready", s_rr, 0);
        s_rstN = 1'b1; s_en = 1'b1;
        #1;
        check("idle_ready", s_rr, 1);
        tick(3);
        check("idle_tresh", s_tr, 15);
        check("idle_drive", s_de, 0);
        check("idle_busy", s_busy, 0);

        // 2. ramp 0 -> 7
        s_rv = 1'b1; s_rd = 4'd7;
        tick();
        s_rv = 1'b0;
        tick();
        check("ramp_busy", s_busy, 1);
        wait_wrap(0, 1);
        check("ramp_p1_cur", s_cd, 0);
        check("ramp_p1_tresh", s_tr, 15);
        wait_wrap(0, 1);
        check("ramp_s1_cur", s_cd, 3);
        check("ramp_s1_tresh", s_tr, 13);
        check("ramp_s1_drive", s_de, 1);
        wait_pcnt(0, 15, "pcnt_15");
        check("ramp_hold_tresh", s_tr, 13);
        wait_wrap(0, 2);
        check("ramp_s2_cur", s_cd, 6);
        check("ramp_s2_tresh", s_tr, 10);
        check("ramp_s2_busy", s_busy, 1);
        wait_wrap(0, 2);
        check("ramp_s3_cur", s_cd, 7);
        check("ramp_s3_tresh", s_tr, 9);
        check("ramp_s3_busy", s_busy, 0);
        tick(20);
        check("hold_cur", s_cd, 7);
        check("hold_busy", s_busy, 0);

        // 3. reset mid-hold, then retarget mid-ramp
        s_rstN = 1'b0;
        tick(2);
        check("rst2_cur", s_cd, 0);
        check("rst2_tresh", s_tr, 15);
        check("rst2_drive", s_de, 0);
        s_rstN = 1'b1;
        tick();
        s_rv = 1'b1; s_rd = 4'd7;
        tick();
        s_rv = 1'b0;
        tick();
        wait_wrap(0, 2);
        check("rt_cur3", s_cd, 3);
        s_rv = 1'b1; s_rd = 4'd1;
        tick();
        s_rv = 1'b0;
        wait_wrap(0, 1);
        check("rt_wait_cur", s_cd, 3);
        wait_wrap(0, 1);
        check("rt_cur1", s_cd, 1);
        check("rt_tresh1", s_tr, 15);
        check("rt_drive1", s_de, 1);
        check("rt_busy1", s_busy, 0);
        s_rv = 1'b1; s_rd = 4'd0;
        tick();
        s_rv = 1'b0;
        tick();
        check("rt0_busy", s_busy, 1);
        wait_wrap(0, 1);
        check("rt0_drive_pre", s_de, 1);
        wait_wrap(0, 1);
        check("rt0_cur", s_cd, 0);
        check("rt0_drive", s_de, 0);
        check("rt0_tresh", s_tr, 15);
        check("rt0_busy_end", s_busy, 0);
        tick(20);
        check("rt0_idle", s_busy, 0);

        // 5. fault and request on the same edge
        s_fin = 1'b1; s_rv = 1'b1; s_rd = 4'd5;
        #1;
        check("sim_ready", s_rr, 0);
        tick();
        s_fin = 1'b0; s_rv = 1'b0;
        #1;
        check("sim_fault", s_fa, 1);
        check("sim_tresh", s_tr, 15);
        check("sim_ready_flt", s_rr, 0);
        s_fclr = 1'b1;
        tick();
        s_fclr = 1'b0;
        check("sim_clr", s_fa, 0);
        tick(3);
        check("sim_no_accept", s_busy, 0);

        // 5b. disable on a step edge
        s_rv = 1'b1; s_rd = 4'd7;
        tick();
        s_rv = 1'b0;
        tick();
        wait_wrap(0, 2);
        check("dis_cur3", s_cd, 3);
        wait_wrap(0, 1);
        wait_pcnt(0, 15, "pcnt_15");
        s_en = 1'b0;
        tick();
        check("dis_cur", s_cd, 0);
        check("dis_drive", s_de, 0);
        check("dis_tresh", s_tr, 15);
        check("dis_busy", s_busy, 0);
        tick(5);
        check("dis_idle", s_busy, 0);
        s_en = 1'b1;
        tick();
        check("reen_busy", s_busy, 1);
        check("reen_cur", s_cd, 0);
        wait_wrap(0, 2);
        check("reen_cur3", s_cd, 3);
        check("reen_tresh", s_tr, 13);

        // 4. fault in hold at 500 (wide build)
        check("b_rst_tresh", b_tr, 1023);
        check("b_rst_ready", b_rr, 0);
        b_rstN = 1'b1; b_en = 1'b1;
        tick();
        b_rv = 1'b1; b_rd = 10'd500;
        tick();
        b_rv = 1'b0;
        tick();
        check("b_busy", b_busy, 1);
        wait_wrap(1, 1);
        check("b_cur500", b_cd, 500);
        check("b_tresh500", b_tr, 524);
        check("b_drive500", b_de, 1);
        check("b_hold", b_busy, 0);
        tick(5);
        b_fin = 1'b1;
        tick();
        check("b_flt_drive", b_de, 0);
        check("b_flt_tresh", b_tr, 1023);
        check("b_flt_active", b_fa, 1);
        check("b_flt_cur", b_cd, 0);
        check("b_flt_ready", b_rr, 0);
        b_fclr = 1'b1;
        tick();
        check("b_clr_ignored", b_fa, 1);
        b_fclr = 1'b0; b_fin = 1'b0;
        #1;
        check("b_flt_ready2", b_rr, 0);
        b_fclr = 1'b1;
        tick();
        b_fclr = 1'b0;
        check("b_clr", b_fa, 0);
        check("b_clr_ready", b_rr, 1);
        tick(3);
        check("b_target0", b_busy, 0);

        // 6. full-scale single step
        b_rv = 1'b1; b_rd = 10'd1023;
        tick();
        b_rv = 1'b0;
        tick();
        wait_wrap(1, 1);
        check("x_cur", b_cd, 1023);
        check("x_tresh", b_tr, 1);
        check("x_drive", b_de, 1);
        hi_cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            if ((m_b >= b_tr) && b_de) hi_cnt++;
            tick();
        end
        check("x_high_cycles", hi_cnt, 1023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
